// File: rtl/jtpang_mainbus.sv
// jtpang_mainbus: Z80 main-bus controller for the PANG-family cores.
// Address decode, banked ROM, ROM wait-state gating of the CPU clock enable,
// VBLANK interrupt generation and a dual-port NVRAM with dump/restore port.
// Build option: define JTPANG_IRQACK_EN to release int_n on a Z80 interrupt
// acknowledge cycle instead of after IRQ_LEN clock-enable pulses.
//
// ROM handshake: rom_cs is the request and stays high while the CPU addresses
// ROM space. rom_ok is the completion flag and is honoured only when rom_addr
// has been stable for at least one clk. The CPU clock enable is withheld in any
// clk where rom_cs=1 and either the address just changed or rom_ok=0.

module jtpang_mainbus #(
    parameter int RAM_AW  = 12,
    parameter int BANK_W  = 4,
    parameter int IRQ_LEN = 64
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cen,
    output logic                cpu_cen,
    input  logic [15:0]         A,
    input  logic                m1_n,
    input  logic                mreq_n,
    input  logic                iorq_n,
    input  logic                rd_n,
    input  logic                wr_n,
    input  logic [7:0]          cpu_dout,
    output logic [7:0]          cpu_din,
    output logic                int_n,
    input  logic                LVBL,
    input  logic                dip_pause,
    output logic                flip,
    output logic [BANK_W-1:0]   bank,
    output logic [14+BANK_W:0]  rom_addr,
    output logic                rom_cs,
    input  logic [7:0]          rom_data,
    input  logic                rom_ok,
    output logic                pal_cs,
    output logic                scr_cs,
    input  logic [7:0]          pal_dout,
    input  logic [7:0]          scr_dout,
    input  logic [7:0]          cab_dout,
    input  logic [RAM_AW-1:0]   prog_addr,
    input  logic [7:0]          prog_data,
    input  logic                prog_we,
    input  logic                prog_ram,
    output logic [7:0]          prog_din,
    output logic                o_irq_st
);

    typedef enum logic {IRQ_IDLE = 1'b0, IRQ_ASSERT = 1'b1} irq_st_t;

    logic [BANK_W-1:0]  r_bank;
    logic               r_flip;
    logic [7:0]         r_cpu_din;
    logic [14+BANK_W:0] r_rom_addr_l;
    logic               r_lvbl_l;
    logic               r_int_n;
    irq_st_t            r_st;
    logic [7:0]         r_mem [0:(2**RAM_AW)-1];
    logic [7:0]         r_prog_din;

    logic               w_mreq;
    logic               w_ram_cs;
    logic [BANK_W:0]    w_bank_p1;
    logic [7:0]         w_ram_dout;
    logic               w_io_rd;
    logic               w_io_wr;
    logic               w_addr_chg;
    logic               w_stall;
    logic               w_lvbl_fall;
    logic               w_ack;
    logic               w_unused_bits;

    // Address decode; refresh cycles are not distinguished from memory cycles
    assign w_mreq    = ~mreq_n;
    assign rom_cs    = w_mreq & (A[15:14] != 2'b11);
    assign pal_cs    = w_mreq & (A[15:11] == 5'b11000);
    assign scr_cs    = w_mreq & (A[15:12] == 4'hD);
    assign w_ram_cs  = w_mreq & (A[15:13] == 3'b111);
    assign w_bank_p1 = {1'b0, r_bank} + {{BANK_W{1'b0}}, 1'b1};
    assign rom_addr  = A[15] ? {w_bank_p1, A[13:0]} : {{BANK_W{1'b0}}, A[14:0]};

    assign w_io_rd   = ~iorq_n & ~rd_n & m1_n;
    assign w_io_wr   = ~iorq_n & ~wr_n & m1_n & (A[7:0] == 8'h00) & cen;
    assign w_ack     = ~m1_n & ~iorq_n;

    // Wait-state gating: a fresh ROM address always costs at least one clk
    assign w_addr_chg = (rom_addr != r_rom_addr_l);
    assign w_stall    = rom_cs & (w_addr_chg | ~rom_ok);
    assign cpu_cen    = rst_n & cen & dip_pause & ~w_stall;

    assign w_lvbl_fall = r_lvbl_l & ~LVBL;
    assign w_ram_dout  = r_mem[A[RAM_AW-1:0]];
    assign w_unused_bits = &{1'b0, cpu_dout};

    assign bank     = r_bank;
    assign flip     = r_flip;
    assign cpu_din  = r_cpu_din;
    assign int_n    = r_int_n;
    assign prog_din = r_prog_din;
    assign o_irq_st = (r_st == IRQ_ASSERT);

    // Remember last clk's ROM address for change detection
    always_ff @(posedge clk) begin
        r_rom_addr_l <= rom_addr;
    end

    // Bank/flip register written through IO port 00h
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_bank <= '0;
            r_flip <= 1'b0;
        end else if (w_io_wr) begin
            r_bank <= cpu_dout[BANK_W-1:0];
            r_flip <= cpu_dout[7];
        end
    end

    // Registered read mux towards the CPU, held while paused
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cpu_din <= 8'hFF;
        end else if (dip_pause) begin
            if (rom_cs)        r_cpu_din <= rom_data;
            else if (w_ram_cs) r_cpu_din <= w_ram_dout;
            else if (pal_cs)   r_cpu_din <= pal_dout;
            else if (scr_cs)   r_cpu_din <= scr_dout;
            else if (w_io_rd)  r_cpu_din <= cab_dout;
            else               r_cpu_din <= 8'hFF;
        end
    end

    // NVRAM: CPU write first so a same-clk prog port write to the same byte wins
    always_ff @(posedge clk) begin
        if (~wr_n & w_ram_cs & cen)
            r_mem[A[RAM_AW-1:0]] <= cpu_dout;
        if (prog_ram & prog_we)
            r_mem[prog_addr] <= prog_data;
        r_prog_din <= r_mem[prog_addr];
    end

`ifdef JTPANG_IRQACK_EN
    // IRQ FSM: assert on LVBL falling edge, release after an acknowledge cycle
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_st     <= IRQ_IDLE;
            r_int_n  <= 1'b1;
            r_lvbl_l <= LVBL;
        end else begin
            r_lvbl_l <= LVBL;
            if (dip_pause) begin
                case (r_st)
                    IRQ_IDLE: begin
                        if (w_lvbl_fall) begin
                            r_st    <= IRQ_ASSERT;
                            r_int_n <= 1'b0;
                        end
                    end
                    IRQ_ASSERT: begin
                        if (!w_lvbl_fall && w_ack) begin
                            r_st    <= IRQ_IDLE;
                            r_int_n <= 1'b1;
                        end
                    end
                    default: begin
                        r_st    <= IRQ_IDLE;
                        r_int_n <= 1'b1;
                    end
                endcase
            end
        end
    end
`else
    localparam int CW = (IRQ_LEN > 1) ? $clog2(IRQ_LEN) : 1;
    localparam logic [CW-1:0] LAST = CW'(IRQ_LEN - 1);
    logic [CW-1:0] r_cnt;
    logic          w_ack_unused;
    assign w_ack_unused = w_ack;

    // IRQ FSM: assert on LVBL falling edge, hold for IRQ_LEN cen pulses
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_st     <= IRQ_IDLE;
            r_int_n  <= 1'b1;
            r_lvbl_l <= LVBL;
            r_cnt    <= '0;
        end else begin
            r_lvbl_l <= LVBL;
            if (dip_pause) begin
                case (r_st)
                    IRQ_IDLE: begin
                        if (w_lvbl_fall) begin
                            r_st    <= IRQ_ASSERT;
                            r_int_n <= 1'b0;
                            r_cnt   <= '0;
                        end
                    end
                    IRQ_ASSERT: begin
                        if (w_lvbl_fall) begin
                            r_cnt <= '0;
                        end else if (cen) begin
                            if (r_cnt == LAST) begin
                                r_st    <= IRQ_IDLE;
                                r_int_n <= 1'b1;
                                r_cnt   <= '0;
                            end else begin
                                r_cnt <= r_cnt + CW'(1);
                            end
                        end
                    end
                    default: begin
                        r_st    <= IRQ_IDLE;
                        r_int_n <= 1'b1;
                        r_cnt   <= '0;
                    end
                endcase
            end
        end
    end
`endif

endmodule

// File: tb/tb_jtpang_mainbus.sv
// Testbench for jtpang_mainbus: directed steps with a queue of expected values.
module tb_jtpang_mainbus;

    localparam int RAM_AW  = 12;
    localparam int BANK_W  = 4;
    localparam int IRQ_LEN = 4;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                cen;
    logic                cpu_cen;
    logic [15:0]         A;
    logic                m1_n, mreq_n, iorq_n, rd_n, wr_n;
    logic [7:0]          cpu_dout;
    logic [7:0]          cpu_din;
    logic                int_n;
    logic                LVBL;
    logic                dip_pause;
    logic                flip;
    logic [BANK_W-1:0]   bank;
    logic [14+BANK_W:0]  rom_addr;
    logic                rom_cs;
    logic [7:0]          rom_data;
    logic                rom_ok;
    logic                pal_cs, scr_cs;
    logic [7:0]          pal_dout, scr_dout, cab_dout;
    logic [RAM_AW-1:0]   prog_addr;
    logic [7:0]          prog_data;
    logic                prog_we, prog_ram;
    logic [7:0]          prog_din;
    logic                o_irq_st;

    logic [31:0] exp_q[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          cnt;
    logic [15:0] rd_a [3];
    logic [7:0]  rd_e [3];

    jtpang_mainbus #(.RAM_AW(RAM_AW), .BANK_W(BANK_W), .IRQ_LEN(IRQ_LEN)) dut (
        .clk(clk), .rst_n(rst_n), .cen(cen), .cpu_cen(cpu_cen), .A(A),
        .m1_n(m1_n), .mreq_n(mreq_n), .iorq_n(iorq_n), .rd_n(rd_n), .wr_n(wr_n),
        .cpu_dout(cpu_dout), .cpu_din(cpu_din), .int_n(int_n), .LVBL(LVBL),
        .dip_pause(dip_pause), .flip(flip), .bank(bank), .rom_addr(rom_addr),
        .rom_cs(rom_cs), .rom_data(rom_data), .rom_ok(rom_ok), .pal_cs(pal_cs),
        .scr_cs(scr_cs), .pal_dout(pal_dout), .scr_dout(scr_dout), .cab_dout(cab_dout),
        .prog_addr(prog_addr), .prog_data(prog_data), .prog_we(prog_we),
        .prog_ram(prog_ram), .prog_din(prog_din), .o_irq_st(o_irq_st)
    );

    // clock
    always #5 clk = ~clk;

    // drivers
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic bus_idle();
        mreq_n = 1'b1; iorq_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1; m1_n = 1'b1;
    endtask

    task automatic io_write(input logic [15:0] addr, input logic [7:0] d);
        A = addr; cpu_dout = d; iorq_n = 1'b0; wr_n = 1'b0;
        tick();
        bus_idle();
    endtask

    // scoreboard
    task automatic push(input logic [31:0] v);
        exp_q.push_back(v);
    endtask

    task automatic check(input string tag, input logic [31:0] obs);
        logic [31:0] e;
        n_tests++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $error("FAIL %s: no expected value queued, observed %0h", tag, obs);
        end else begin
            e = exp_q.pop_front();
            assert (obs === e) else begin
                n_fail++;
                $error("FAIL %s: observed %0h expected %0h", tag, obs, e);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; cen = 1'b1; A = 16'h8000; bus_idle();
        cpu_dout = 8'h00; LVBL = 1'b0; dip_pause = 1'b1;
        rom_data = 8'h11; rom_ok = 1'b1;
        pal_dout = 8'h22; scr_dout = 8'h33; cab_dout = 8'h44;
        prog_addr = '0; prog_data = 8'h00; prog_we = 1'b0; prog_ram = 1'b0;
        mreq_n = 1'b0; rd_n = 1'b0;

        // reset with LVBL toggling, last reset clk sees LVBL=0
        for (int i = 0; i < 6; i++) begin
            LVBL = ~LVBL;
            tick();
        end
        smp();
        push(1);        check("rst_int_n", int_n);
        push(0);        check("rst_bank", bank);
        push(0);        check("rst_flip", flip);
        push(8'hFF);    check("rst_cpu_din", cpu_din);
        push(0);        check("rst_cpu_cen", cpu_cen);
        push(19'h04000); check("rst_bank_addr", rom_addr);
        rst_n = 1'b1;
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            tick(); smp();
            if (!int_n) cnt++;
        end
        push(0);        check("rst_no_irq", cnt);
        tick(); bus_idle();

        // bank / flip register
        io_write(16'h1200, 8'h83);
        smp();
        push(3);        check("bank_wr", bank);
        push(1);        check("flip_wr", flip);
        tick();
        io_write(16'h0001, 8'h05);
        smp();
        push(3);        check("io_other_port", bank);
        tick();
        cen = 1'b0;
        io_write(16'h0000, 8'h05);
        cen = 1'b1;
        smp();
        push(3);        check("io_no_cen", bank);
        tick();

        // banked ROM read
        A = 16'h8123; mreq_n = 1'b0; rd_n = 1'b0; rom_data = 8'hA7;
        smp();
        push(19'h10123); check("bank_rom_addr", rom_addr);
        push(1);        check("bank_rom_cs", rom_cs);
        tick(); smp();
        push(8'hA7);    check("rom_din", cpu_din);

        // other read sources
        rd_a[0] = 16'hC100; rd_e[0] = 8'h22;
        rd_a[1] = 16'hD800; rd_e[1] = 8'h33;
        rd_a[2] = 16'hC900; rd_e[2] = 8'hFF;
        for (int i = 0; i < 3; i++) begin
            tick();
            A = rd_a[i];
            smp();
            push({31'd0, i == 0}); check("pal_cs", pal_cs);
            push({31'd0, i == 1}); check("scr_cs", scr_cs);
            tick(); smp();
            push(rd_e[i]);  check("rd_mux", cpu_din);
        end
        tick();
        bus_idle(); A = 16'h0001; iorq_n = 1'b0; rd_n = 1'b0;
        tick(); smp();
        push(8'h44);    check("io_rd_din", cpu_din);
        tick(); bus_idle();

        // ROM wait states
        A = 16'h0010; mreq_n = 1'b0; rd_n = 1'b0; rom_ok = 1'b0;
        cnt = 0;
        for (int i = 0; i < 5; i++) begin
            smp();
            if (!cpu_cen) cnt++;
            tick();
        end
        rom_ok = 1'b1;
        smp();
        push(5);        check("rom_stall_len", cnt);
        push(1);        check("rom_resume", cpu_cen);
        tick();
        A = 16'h0020;
        cnt = 0;
        for (int i = 0; i < 4; i++) begin
            smp();
            if (!cpu_cen) cnt++;
            tick();
        end
        push(1);        check("rom_chg_stall", cnt);
        dip_pause = 1'b0;
        smp();
        push(0);        check("pause_cen", cpu_cen);
        tick();
        dip_pause = 1'b1; A = 16'hE000; rom_ok = 1'b0;
        smp();
        push(1);        check("ram_no_stall", cpu_cen);
        tick();
        rom_ok = 1'b1; bus_idle();

        // VBLANK interrupt
        LVBL = 1'b1; tick(); tick();
`ifdef JTPANG_IRQACK_EN
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            LVBL = 1'b0;
            smp();
            if (!int_n) cnt++;
            tick();
        end
        push(7);        check("irq_hold", cnt);
        m1_n = 1'b0; iorq_n = 1'b0;
        smp();
        push(0);        check("irq_ack_cycle", int_n);
        tick(); bus_idle(); smp();
        push(1);        check("irq_ack_rel", int_n);
        tick();
        LVBL = 1'b1; tick(); tick();
        LVBL = 1'b0; tick(); tick();
        dip_pause = 1'b0; m1_n = 1'b0; iorq_n = 1'b0;
        tick(); tick(); smp();
        push(0);        check("irq_ack_paused", int_n);
        dip_pause = 1'b1;
        tick(); bus_idle(); smp();
        push(1);        check("irq_ack_after_pause", int_n);
        tick();
`else
        cnt = 0;
        for (int i = 0; i < 12; i++) begin
            LVBL = 1'b0;
            if (i == 2) begin m1_n = 1'b0; iorq_n = 1'b0; end
            else bus_idle();
            smp();
            if (!int_n) cnt++;
            tick();
        end
        push(IRQ_LEN);  check("irq_len", cnt);
        LVBL = 1'b1; tick(); tick();
        cnt = 0;
        for (int i = 0; i < 12; i++) begin
            LVBL = 1'b0;
            dip_pause = !(i >= 2 && i <= 4);
            smp();
            if (!int_n) cnt++;
            tick();
        end
        push(IRQ_LEN + 3); check("irq_pause_ext", cnt);
        LVBL = 1'b1; tick(); tick();
        cnt = 0;
        for (int i = 0; i < 12; i++) begin
            LVBL = (i == 1);
            smp();
            if (!int_n) cnt++;
            tick();
        end
        push(IRQ_LEN + 2); check("irq_restart", cnt);
        smp();
        push(1);        check("irq_end_high", int_n);
        tick();
`endif

        // NVRAM
        A = 16'hE123; cpu_dout = 8'h5A; mreq_n = 1'b0; wr_n = 1'b0;
        tick(); bus_idle();
        prog_ram = 1'b1; prog_addr = 12'h123;
        tick(); smp();
        push(8'h5A);    check("nv_dump", prog_din);
        tick();
        A = 16'hF123; mreq_n = 1'b0; rd_n = 1'b0;
        tick(); smp();
        push(8'h5A);    check("nv_mirror", cpu_din);
        tick(); bus_idle();
        A = 16'hE123; cpu_dout = 8'hA5; mreq_n = 1'b0; wr_n = 1'b0;
        prog_we = 1'b1; prog_data = 8'h3C;
        tick();
        bus_idle(); prog_we = 1'b0;
        mreq_n = 1'b0; rd_n = 1'b0;
        tick(); smp();
        push(8'h3C);    check("nv_coll_prog", prog_din);
        push(8'h3C);    check("nv_coll_cpu", cpu_din);
        tick();
        prog_addr = 12'h200; prog_data = 8'h77; prog_we = 1'b1;
        tick(); prog_we = 1'b0;
        A = 16'hE200;
        tick(); smp();
        push(8'h77);    check("nv_restore", cpu_din);
        tick();
        rst_n = 1'b0; tick(); tick(); rst_n = 1'b1;
        A = 16'hE123;
        tick(); smp();
        push(8'h3C);    check("nv_keep_rst", cpu_din);

        if (exp_q.size() != 0) begin
            n_tests++;
            n_fail++;
            $error("FAIL sb_leftover: observed %0d expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
